g06_input_conditioner: RTL

//  Upstream front end for the SHA256 system's PIO inputs. Synchronises and debounces the
//  raw DE1-SoC KEY[3:0] and SW[9:0] pins, then drives pushbuttons_export and switches_export.

---
 rtl/g06_input_conditioner.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/g06_input_conditioner.sv
// g06_input_conditioner: synchronises and debounces raw DE1-SoC KEY/SW pins for the
// SHA256 system PIOs, and emits one-cycle press/release/change pulses for local logic.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES edges from raw pin to debounced level, counting
// the sampling edge as the first; pulses are coincident with the level change.
// Backpressure: none; free-running pin conditioner, outputs are levels and pulses.
// Optional feature: define G06_KEY_AUTOREPEAT_EN for per-key hold auto-repeat on key_press.
// Ports:
//   clk_clk, reset_reset_n        clock, async active-low reset
//   key_n_raw[N_KEYS], sw_raw[N_SW]  raw asynchronous pins (keys active-low)
//   pushbuttons_export, switches_export  debounced levels (keys active-high)
//   key_press, key_release, sw_change    one-cycle event pulses

module g06_input_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int N_SW            = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [N_KEYS-1:0] key_n_raw,
  input  logic [N_SW-1:0]   sw_raw,
  output logic [N_KEYS-1:0] pushbuttons_export,
  output logic [N_SW-1:0]   switches_export,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              sw_change
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------- synchronisers
  // Stage 0 takes the raw pin; the last stage is the synchronised value.
  logic [SYNC_STAGES-1:0][N_KEYS-1:0] r_key_sync;
  logic [SYNC_STAGES-1:0][N_SW-1:0]   r_sw_sync;
  logic [N_KEYS-1:0]                  w_key_s;
  logic [N_SW-1:0]                    w_sw_s;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_key_sync <= '1;   // keys idle high (released)
      r_sw_sync  <= '0;
    end else begin
      r_key_sync <= {r_key_sync[SYNC_STAGES-2:0], key_n_raw};
      r_sw_sync  <= {r_sw_sync[SYNC_STAGES-2:0], sw_raw};
    end
  end

  assign w_key_s = ~r_key_sync[SYNC_STAGES-1];
  assign w_sw_s  = r_sw_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------- key debounce
  logic [N_KEYS-1:0] r_key_lvl;
  logic [N_KEYS-1:0] r_key_press;
  logic [N_KEYS-1:0] r_key_release;
  logic [CNT_W-1:0]  r_key_cnt [N_KEYS];
  logic [N_KEYS-1:0] w_key_hit;
  logic [N_KEYS-1:0] w_press_evt;
  logic [N_KEYS-1:0] w_rel_evt;
  logic [N_KEYS-1:0] w_rpt_fire;

  // A key flips when it has mismatched for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    w_key_hit = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_key_hit[i] = (w_key_s[i] != r_key_lvl[i]) && (r_key_cnt[i] == DB_LAST);
    end
  end

  assign w_press_evt = w_key_hit & w_key_s;
  assign w_rel_evt   = w_key_hit & ~w_key_s;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_key_lvl     <= '0;
      r_key_press   <= '0;
      r_key_release <= '0;
      for (int i = 0; i < N_KEYS; i++) r_key_cnt[i] <= '0;
    end else begin
      r_key_lvl     <= r_key_lvl ^ w_key_hit;
      r_key_press   <= w_press_evt | w_rpt_fire;
      r_key_release <= w_rel_evt;
      // Counter clears on match (bounce) or on the flip; never passes DB_LAST.
      for (int i = 0; i < N_KEYS; i++) begin
        if ((w_key_s[i] == r_key_lvl[i]) || w_key_hit[i]) r_key_cnt[i] <= '0;
        else                                              r_key_cnt[i] <= r_key_cnt[i] + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- switch debounce
  logic [N_SW-1:0]  r_sw_prev;
  logic [N_SW-1:0]  r_sw_lvl;
  logic [CNT_W-1:0] r_sw_cnt;
  logic             r_sw_chg;
  logic [CNT_W-1:0] w_sw_cnt_eff;
  logic             w_sw_hit;

  // A cycle where the vector moved counts as count 0 of a fresh window, so a single
  // clean change has the same latency as a key.
  assign w_sw_cnt_eff = (w_sw_s != r_sw_prev) ? '0 : r_sw_cnt;
  assign w_sw_hit     = (w_sw_s != r_sw_lvl) && (w_sw_cnt_eff == DB_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sw_prev <= '0;
      r_sw_lvl  <= '0;
      r_sw_cnt  <= '0;
      r_sw_chg  <= 1'b0;
    end else begin
      r_sw_prev <= w_sw_s;
      r_sw_chg  <= w_sw_hit;
      if (w_sw_hit) r_sw_lvl <= w_sw_s;
      if ((w_sw_s == r_sw_lvl) || w_sw_hit) r_sw_cnt <= '0;
      else                                  r_sw_cnt <= w_sw_cnt_eff + 1'b1;
    end
  end

  // ---------------------------------------------------------------- auto-repeat
`ifdef G06_KEY_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HELD_DELAY,
    RPT_HELD_REPEAT
  } rpt_state_t;

  rpt_state_t       r_rpt_state   [N_KEYS];
  rpt_state_t       w_rpt_state_nxt [N_KEYS];
  logic [RPT_W-1:0] r_rpt_tmr     [N_KEYS];
  logic [RPT_W-1:0] w_rpt_tmr_nxt [N_KEYS];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < N_KEYS; i++) begin
        r_rpt_state[i] <= RPT_IDLE;
        r_rpt_tmr[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        r_rpt_state[i] <= w_rpt_state_nxt[i];
        r_rpt_tmr[i]   <= w_rpt_tmr_nxt[i];
      end
    end
  end

  // Timer starts at 0 on the edge of the press pulse, so the first repeat lands
  // exactly REPEAT_DELAY edges after it. A release event wins over a due repeat.
  always_comb begin
    w_rpt_fire = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_rpt_state_nxt[i] = r_rpt_state[i];
      w_rpt_tmr_nxt[i]   = r_rpt_tmr[i];
      case (r_rpt_state[i])
        RPT_IDLE: begin
          if (w_press_evt[i]) begin
            w_rpt_state_nxt[i] = RPT_HELD_DELAY;
            w_rpt_tmr_nxt[i]   = '0;
          end
        end
        RPT_HELD_DELAY, RPT_HELD_REPEAT: begin
          if (w_rel_evt[i] || !r_key_lvl[i]) begin
            w_rpt_state_nxt[i] = RPT_IDLE;
            w_rpt_tmr_nxt[i]   = '0;
          end else if (r_rpt_tmr[i] == ((r_rpt_state[i] == RPT_HELD_DELAY) ? RPT_DLY_LAST
                                                                          : RPT_PER_LAST)) begin
            w_rpt_fire[i]      = 1'b1;
            w_rpt_state_nxt[i] = RPT_HELD_REPEAT;
            w_rpt_tmr_nxt[i]   = '0;
          end else begin
            w_rpt_tmr_nxt[i] = r_rpt_tmr[i] + 1'b1;
          end
        end
        default: begin
          w_rpt_state_nxt[i] = RPT_IDLE;
          w_rpt_tmr_nxt[i]   = '0;
        end
      endcase
    end
  end
`else
  logic w_unused_rpt;
  assign w_rpt_fire   = '0;
  assign w_unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  // ---------------------------------------------------------------- outputs
  assign pushbuttons_export = r_key_lvl;
  assign switches_export    = r_sw_lvl;
  assign key_press          = r_key_press;
  assign key_release        = r_key_release;
  assign sw_change          = r_sw_chg;

endmodule
